// File: rtl/mips_fetch_queue_if.sv
// mips_fetch_queue_if
// Bundles the fetch queue's I-cache, redirect and decode-side signals.
//   master : fetch queue side (drives I-cache request and the decode head)
//   slave  : environment side (I-cache, branch unit, decode stage)
// Signals:
//   icache_addr/icache_ren      fetch request (word address)
//   icache_rdata/icache_stall   I-cache response / miss in progress
//   redirect_valid/redirect_pc  one-cycle resteer pulse and target
//   id_ready                    decode accepts the queue head
//   id_valid/id_instr/id_pc/id_pc_plus1  queue head
//   q_count                     queue occupancy
interface mips_fetch_queue_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned QDEPTH = 4
);
  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  logic [ADDR_W-1:0] icache_addr;
  logic              icache_ren;
  logic [DATA_W-1:0] icache_rdata;
  logic              icache_stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_ready;
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus1;
  logic [CntW-1:0]   q_count;

  modport master (
    output icache_addr, icache_ren, id_valid, id_instr, id_pc, id_pc_plus1, q_count,
    input  icache_rdata, icache_stall, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  icache_addr, icache_ren, id_valid, id_instr, id_pc, id_pc_plus1, q_count,
    output icache_rdata, icache_stall, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue
// Instruction-fetch front end: owns the fetch PC, issues I-cache requests and
// buffers returned words in a QDEPTH-entry FIFO feeding decode. Redirects flush
// the queue; a redirect that lands during an I-cache miss parks the target in
// pending_pc and waits (StDrain) for the stale response before resteering.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   io_bus mips_fetch_queue_if.master (I-cache, redirect and decode signals)
module mips_fetch_queue #(
  parameter int unsigned ADDR_W   = 30,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned RESET_PC = 0
) (
  input logic                clk,
  input logic                rst_n,
  mips_fetch_queue_if.master io_bus
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e            r_state,      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc,   w_fetch_pc_nxt;
  logic [ADDR_W-1:0] r_pending_pc, w_pending_pc_nxt;
  logic              r_req_hold,   w_req_hold_nxt;
  logic [PtrW-1:0]   r_wr_ptr,     w_wr_ptr_nxt;
  logic [PtrW-1:0]   r_rd_ptr,     w_rd_ptr_nxt;
  logic [CntW-1:0]   r_count,      w_count_nxt;

  logic [DATA_W-1:0] r_instr_q [QDEPTH];
  logic [ADDR_W-1:0] r_pc_q    [QDEPTH];

  logic w_full;
  logic w_ren;
  logic w_id_valid;
  logic w_push;
  logic w_pop;

  // Request side depends on registered state only, never on id_ready/redirect.
  assign w_full     = (r_count == CntW'(QDEPTH));
  assign w_ren      = (r_state == StDrain) | r_req_hold | ~w_full;
  assign w_id_valid = (r_state == StRun) && (r_count != '0);

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_pc_nxt   = r_fetch_pc;
    w_pending_pc_nxt = r_pending_pc;
    w_req_hold_nxt   = r_req_hold;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_count_nxt      = r_count;
    w_push           = 1'b0;
    w_pop            = 1'b0;

    unique case (r_state)
      StRun: begin
        if (io_bus.redirect_valid) begin
          // Flush; any same-cycle response or pop is discarded.
          w_count_nxt  = '0;
          w_wr_ptr_nxt = '0;
          w_rd_ptr_nxt = '0;
          if (w_ren && io_bus.icache_stall) begin
            // Miss outstanding: cannot change the address until it returns.
            w_pending_pc_nxt = io_bus.redirect_pc;
            w_req_hold_nxt   = 1'b1;
            w_state_nxt      = StDrain;
          end else begin
            w_fetch_pc_nxt = io_bus.redirect_pc;
            w_req_hold_nxt = 1'b0;
          end
        end else begin
          if (w_ren) begin
            if (io_bus.icache_stall) begin
              w_req_hold_nxt = 1'b1;
            end else begin
              w_push         = 1'b1;
              w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(1);
              w_req_hold_nxt = 1'b0;
            end
          end
          w_pop = w_id_valid & io_bus.id_ready;

          if (w_push) w_wr_ptr_nxt = r_wr_ptr + PtrW'(1);
          if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PtrW'(1);
          case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CntW'(1);
            2'b01:   w_count_nxt = r_count - CntW'(1);
            default: w_count_nxt = r_count;
          endcase
        end
      end

      StDrain: begin
        if (io_bus.redirect_valid) w_pending_pc_nxt = io_bus.redirect_pc;
        if (!io_bus.icache_stall) begin
          // Stale response is dropped; the newest redirect target wins.
          w_fetch_pc_nxt = io_bus.redirect_valid ? io_bus.redirect_pc : r_pending_pc;
          w_req_hold_nxt = 1'b0;
          w_state_nxt    = StRun;
        end
      end

      default: w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StRun;
      r_fetch_pc   <= ADDR_W'(RESET_PC);
      r_pending_pc <= '0;
      r_req_hold   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_pc   <= w_fetch_pc_nxt;
      r_pending_pc <= w_pending_pc_nxt;
      r_req_hold   <= w_req_hold_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_instr_q[r_wr_ptr] <= io_bus.icache_rdata;
      r_pc_q[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  always_comb begin
    io_bus.icache_addr = r_fetch_pc;
    io_bus.icache_ren  = w_ren;
    io_bus.id_valid    = w_id_valid;
    io_bus.q_count     = r_count;
    io_bus.id_instr    = '0;
    io_bus.id_pc       = '0;
    io_bus.id_pc_plus1 = '0;
    if (w_id_valid) begin
      io_bus.id_instr    = r_instr_q[r_rd_ptr];
      io_bus.id_pc       = r_pc_q[r_rd_ptr];
      io_bus.id_pc_plus1 = r_pc_q[r_rd_ptr] + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue: one DUT at RESET_PC=0 for the main
// scenarios, a second at RESET_PC=2^30-2 for address wrap. Memory word k is
// 0x1000_0000+k.
module tb_mips_fetch_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mips_fetch_queue_if #(.ADDR_W(30), .DATA_W(32), .QDEPTH(4)) bus ();
  mips_fetch_queue_if #(.ADDR_W(30), .DATA_W(32), .QDEPTH(4)) bus2 ();

  mips_fetch_queue #(.ADDR_W(30), .DATA_W(32), .QDEPTH(4), .RESET_PC(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  mips_fetch_queue #(.ADDR_W(30), .DATA_W(32), .QDEPTH(4), .RESET_PC(32'h3FFF_FFFE)) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus2)
  );

  always_comb bus.icache_rdata  = 32'h1000_0000 + 32'(bus.icache_addr);
  always_comb bus2.icache_rdata = 32'h1000_0000 + 32'(bus2.icache_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    bus.icache_stall   = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bus.icache_addr !== 30'h0) begin n_err++;
      $display("FAIL reset_addr: got %h want %h", bus.icache_addr, 30'h0); end
    n_vec++; if (bus.icache_ren !== 1'b1) begin n_err++;
      $display("FAIL reset_ren: got %b want 1", bus.icache_ren); end
    n_vec++; if (bus.id_valid !== 1'b0) begin n_err++;
      $display("FAIL reset_valid: got %b want 0", bus.id_valid); end
    n_vec++; if (bus.id_instr !== 32'h0) begin n_err++;
      $display("FAIL reset_instr: got %h want 0", bus.id_instr); end
    n_vec++; if (bus.id_pc !== 30'h0 || bus.id_pc_plus1 !== 30'h0) begin n_err++;
      $display("FAIL reset_pc: got %h/%h want 0/0", bus.id_pc, bus.id_pc_plus1); end
    n_vec++; if (bus.q_count !== 3'd0) begin n_err++;
      $display("FAIL reset_count: got %0d want 0", bus.q_count); end
  endtask

  task automatic test_stream();
    do_reset();
    bus.id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_vec++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 30'(k)) begin n_err++;
        $display("FAIL stream_pc[%0d]: got v=%b pc=%h want v=1 pc=%h", k, bus.id_valid,
                 bus.id_pc, 30'(k)); end
      n_vec++; if (bus.id_instr !== 32'h1000_0000 + 32'(k)) begin n_err++;
        $display("FAIL stream_instr[%0d]: got %h want %h", k, bus.id_instr,
                 32'h1000_0000 + 32'(k)); end
      n_vec++; if (bus.id_pc_plus1 !== 30'(k + 1) || bus.icache_addr !== 30'(k + 1)) begin
        n_err++;
        $display("FAIL stream_next[%0d]: got plus1=%h addr=%h want %h", k, bus.id_pc_plus1,
                 bus.icache_addr, 30'(k + 1)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.id_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_vec++; if (bus.icache_ren !== 1'b0 || bus.q_count !== 3'd4) begin n_err++;
      $display("FAIL bp_full: got ren=%b count=%0d want ren=0 count=4", bus.icache_ren,
               bus.q_count); end
    n_vec++; if (bus.icache_addr !== 30'h4 || bus.id_pc !== 30'h0) begin n_err++;
      $display("FAIL bp_state: got addr=%h head=%h want 4/0", bus.icache_addr, bus.id_pc); end
    bus.id_ready = 1'b1;
    tick();
    n_vec++; if (bus.q_count !== 3'd3 || bus.icache_ren !== 1'b1) begin n_err++;
      $display("FAIL bp_pop_no_push: got count=%0d ren=%b want 3/1", bus.q_count,
               bus.icache_ren); end
    for (int j = 1; j <= 6; j++) begin
      n_vec++; if (bus.id_pc !== 30'(j) || bus.id_instr !== 32'h1000_0000 + 32'(j)) begin
        n_err++;
        $display("FAIL bp_order[%0d]: got pc=%h instr=%h want pc=%h", j, bus.id_pc,
                 bus.id_instr, 30'(j)); end
      tick();
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.id_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    bus.icache_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++; if (bus.icache_addr !== 30'h5 || bus.icache_ren !== 1'b1) begin n_err++;
        $display("FAIL stall_hold[%0d]: got addr=%h ren=%b want 5/1", k, bus.icache_addr,
                 bus.icache_ren); end
      n_vec++; if (bus.id_valid !== 1'b0) begin n_err++;
        $display("FAIL stall_empty[%0d]: got valid=%b want 0", k, bus.id_valid); end
    end
    bus.icache_stall = 1'b0;
    tick();
    n_vec++; if (bus.id_pc !== 30'h5 || bus.icache_addr !== 30'h6) begin n_err++;
      $display("FAIL stall_word5: got pc=%h addr=%h want 5/6", bus.id_pc, bus.icache_addr); end
    tick();
    n_vec++; if (bus.id_pc !== 30'h6 || bus.q_count !== 3'd1) begin n_err++;
      $display("FAIL stall_once: got pc=%h count=%0d want 6/1", bus.id_pc, bus.q_count); end
  endtask

  task automatic test_redirect_run();
    do_reset();
    bus.id_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_vec++; if (bus.q_count !== 3'd3) begin n_err++;
      $display("FAIL redir_pre: got count=%0d want 3", bus.q_count); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 30'h200;
    tick();
    bus.redirect_valid = 1'b0;
    n_vec++; if (bus.q_count !== 3'd0 || bus.id_valid !== 1'b0) begin n_err++;
      $display("FAIL redir_flush: got count=%0d valid=%b want 0/0", bus.q_count,
               bus.id_valid); end
    n_vec++; if (bus.icache_addr !== 30'h200) begin n_err++;
      $display("FAIL redir_addr: got %h want %h", bus.icache_addr, 30'h200); end
    bus.id_ready = 1'b1;
    tick();
    n_vec++; if (bus.id_pc !== 30'h200 || bus.id_instr !== 32'h1000_0200) begin n_err++;
      $display("FAIL redir_first: got pc=%h instr=%h want 200/10000200", bus.id_pc,
               bus.id_instr); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    bus.id_ready = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    bus.icache_stall = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 30'h300;
    tick();
    n_vec++; if (bus.icache_addr !== 30'h7 || bus.icache_ren !== 1'b1 ||
                 bus.id_valid !== 1'b0) begin n_err++;
      $display("FAIL drain_hold: got addr=%h ren=%b valid=%b want 7/1/0", bus.icache_addr,
               bus.icache_ren, bus.id_valid); end
    bus.redirect_pc = 30'h400;
    tick();
    bus.redirect_valid = 1'b0;
    bus.icache_stall   = 1'b0;
    tick();
    n_vec++; if (bus.icache_addr !== 30'h400 || bus.id_valid !== 1'b0) begin n_err++;
      $display("FAIL drain_exit: got addr=%h valid=%b want 400/0", bus.icache_addr,
               bus.id_valid); end
    tick();
    n_vec++; if (bus.id_pc !== 30'h400 || bus.id_instr !== 32'h1000_0400) begin n_err++;
      $display("FAIL drain_first: got pc=%h instr=%h want 400/10000400", bus.id_pc,
               bus.id_instr); end
  endtask

  task automatic test_drain_reset();
    do_reset();
    bus.id_ready     = 1'b1;
    bus.icache_stall = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 30'h500;
    tick();
    bus.redirect_pc  = 30'h600;
    bus.icache_stall = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    n_vec++; if (bus.icache_addr !== 30'h600) begin n_err++;
      $display("FAIL drain_same_cycle: got %h want %h", bus.icache_addr, 30'h600); end
    bus.icache_stall = 1'b1;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 30'h700;
    tick();
    bus.redirect_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_vec++; if (bus.icache_addr !== 30'h0 || bus.icache_ren !== 1'b1) begin n_err++;
      $display("FAIL drain_rst_req: got addr=%h ren=%b want 0/1", bus.icache_addr,
               bus.icache_ren); end
    n_vec++; if (bus.id_valid !== 1'b0 || bus.q_count !== 3'd0 || bus.id_pc !== 30'h0) begin
      n_err++;
      $display("FAIL drain_rst_id: got valid=%b count=%0d pc=%h want 0/0/0", bus.id_valid,
               bus.q_count, bus.id_pc); end
    rst_n            = 1'b1;
    bus.icache_stall = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    n_vec++; if (bus2.id_pc !== 30'h3FFF_FFFE || bus2.id_pc_plus1 !== 30'h3FFF_FFFF) begin
      n_err++;
      $display("FAIL wrap0: got %h/%h want 3ffffffe/3fffffff", bus2.id_pc, bus2.id_pc_plus1);
    end
    tick();
    n_vec++; if (bus2.id_pc !== 30'h3FFF_FFFF || bus2.id_pc_plus1 !== 30'h0) begin n_err++;
      $display("FAIL wrap1: got %h/%h want 3fffffff/0", bus2.id_pc, bus2.id_pc_plus1); end
    tick();
    n_vec++; if (bus2.id_pc !== 30'h0 || bus2.id_instr !== 32'h1000_0000) begin n_err++;
      $display("FAIL wrap2: got pc=%h instr=%h want 0/10000000", bus2.id_pc, bus2.id_instr);
    end
  endtask

  initial begin
    bus2.icache_stall   = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.id_ready       = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_redirect_run();
    test_redirect_drain();
    test_drain_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
